// File: rtl/rom_dl_sdram_writer.sv
// rom_dl_sdram_writer: packs data_io ROM download bytes into 16-bit words with
// lane masks, buffers them in a small FIFO and writes them through the SDRAM
// controller's port1 req/ack channel. rom_loaded rises once every byte of the
// finished download has been acknowledged by the controller.
module rom_dl_sdram_writer #(
  parameter int          DEPTH      = 4,
  parameter logic [24:0] ADDR_LIMIT = 25'h10000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_downl,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [21:0] port1_addr,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_din,
  output logic        port1_we,
  output logic        rom_loaded,
  output logic        overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  typedef enum logic {ST_IDLE, ST_REQ} state_t;

  state_t            state_q, state_d;
  logic              downl_q, downl_d;
  logic              fall_q, fall_d;
  logic              seen_fall_q, seen_fall_d;
  logic              pvalid_q, pvalid_d;
  logic [21:0]       paddr_q, paddr_d;
  logic [1:0]        pds_q, pds_d;
  logic [15:0]       pdata_q, pdata_d;
  logic [39:0]       mem_q [DEPTH];
  logic [39:0]       mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              req_q, req_d;
  logic [21:0]       addr_q, addr_d;
  logic [1:0]        ds_q, ds_d;
  logic [15:0]       din_q, din_d;
  logic              rom_loaded_q, rom_loaded_d;
  logic              overflow_q, overflow_d;

  logic              accept, lane, rise, full, empty, pop, do_push, push_en;
  logic [21:0]       waddr;
  logic [1:0]        lane_ds, merged_ds;
  logic [15:0]       lane_data, merged_data;
  logic [39:0]       push_word;

  assign accept    = ioctl_wr && (ioctl_addr < ADDR_LIMIT);
  assign lane      = ioctl_addr[0];
  assign waddr     = ioctl_addr[22:1];
  assign lane_ds   = lane ? 2'b10 : 2'b01;
  assign lane_data = lane ? {ioctl_dout, 8'h00} : {8'h00, ioctl_dout};
  assign rise      = ioctl_downl && !downl_q;
  assign full      = (count_q == FULL_COUNT);
  assign empty     = (count_q == '0);
  assign pop       = (state_q == ST_REQ) && port1_ack;
  assign do_push   = push_en && !full;

  assign port1_req  = req_q;
  assign port1_addr = addr_q;
  assign port1_ds   = ds_q;
  assign port1_din  = din_q;
  assign port1_we   = downl_q || !empty || req_q;
  assign rom_loaded = rom_loaded_q;
  assign overflow   = overflow_q;

  // Byte assembler: merge strobes into the pending word, emit a push when it fills or is displaced
  always_comb begin
    pvalid_d    = pvalid_q;
    paddr_d     = paddr_q;
    pds_d       = pds_q;
    pdata_d     = pdata_q;
    push_en     = 1'b0;
    push_word   = {paddr_q, pds_q, pdata_q};
    merged_ds   = pds_q | lane_ds;
    merged_data = lane ? {ioctl_dout, pdata_q[7:0]} : {pdata_q[15:8], ioctl_dout};
    if (accept) begin
      if (pvalid_q && (waddr == paddr_q) && ((pds_q & lane_ds) == 2'b00)) begin
        if (merged_ds == 2'b11) begin
          push_en   = 1'b1;
          push_word = {paddr_q, 2'b11, merged_data};
          pvalid_d  = 1'b0;
        end else begin
          pds_d   = merged_ds;
          pdata_d = merged_data;
        end
      end else begin
        push_en  = pvalid_q;
        pvalid_d = 1'b1;
        paddr_d  = waddr;
        pds_d    = lane_ds;
        pdata_d  = lane_data;
      end
    end else if (fall_q && pvalid_q) begin
      push_en  = 1'b1;
      pvalid_d = 1'b0;
    end
  end

  // FIFO bookkeeping, port1 request FSM and download status flags
  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    state_d      = state_q;
    req_d        = req_q;
    addr_d       = addr_q;
    ds_d         = ds_q;
    din_d        = din_q;
    downl_d      = ioctl_downl;
    fall_d       = downl_q && !ioctl_downl;
    seen_fall_d  = seen_fall_q || fall_q;
    rom_loaded_d = rom_loaded_q;
    overflow_d   = overflow_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = push_word;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          {addr_d, ds_d, din_d} = mem_q[rd_ptr_q];
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (port1_ack) begin
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (rise) begin
      seen_fall_d  = 1'b0;
      rom_loaded_d = 1'b0;
      overflow_d   = 1'b0;
    end
    if (push_en && full) begin
      overflow_d = 1'b1;
    end
    if (!ioctl_downl && empty && (state_q == ST_IDLE) && !pvalid_q && seen_fall_q) begin
      rom_loaded_d = 1'b1;
    end
  end

  // State registers; the FIFO storage itself needs no reset because count gates every read
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      downl_q      <= 1'b0;
      fall_q       <= 1'b0;
      seen_fall_q  <= 1'b0;
      pvalid_q     <= 1'b0;
      paddr_q      <= '0;
      pds_q        <= '0;
      pdata_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      req_q        <= 1'b0;
      addr_q       <= '0;
      ds_q         <= '0;
      din_q        <= '0;
      rom_loaded_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      downl_q      <= downl_d;
      fall_q       <= fall_d;
      seen_fall_q  <= seen_fall_d;
      pvalid_q     <= pvalid_d;
      paddr_q      <= paddr_d;
      pds_q        <= pds_d;
      pdata_q      <= pdata_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      ds_q         <= ds_d;
      din_q        <= din_d;
      rom_loaded_q <= rom_loaded_d;
      overflow_q   <= overflow_d;
    end
  end

endmodule

// File: tb/tb_rom_dl_sdram_writer.sv
// tb_rom_dl_sdram_writer: directed and randomized ROM download sequences; every
// word acknowledged on port1 is compared in order against a word list built
// from the byte-pairing rules.
module tb_rom_dl_sdram_writer;

   localparam logic [24:0] LIMIT = 25'h10000;
   localparam int          DEPTH = 4;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        ioctl_downl = 1'b0;
   logic        ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_dout = '0;
   logic        port1_ack = 1'b0;
   logic        port1_req;
   logic [21:0] port1_addr;
   logic [1:0]  port1_ds;
   logic [15:0] port1_din;
   logic        port1_we;
   logic        rom_loaded;
   logic        overflow;

   typedef struct packed {
      logic [21:0] addr;
      logic [1:0]  ds;
      logic [15:0] din;
   } word_t;

   typedef struct {
      word_t w;
      logic  stable;
      logic  loaded;
   } obs_t;

   int    vectors = 0;
   int    miscompares = 0;
   word_t exp_q[$];
   obs_t  obs_q[$];
   int    obs_rd = 0;
   logic  m_pvalid = 1'b0;
   word_t m_pend = '0;
   logic  ack_en = 1'b1;
   int    force_cnt = 0;

   // Free-running clock
   always #5 clk_sys = ~clk_sys;

   rom_dl_sdram_writer #(.DEPTH(DEPTH), .ADDR_LIMIT(LIMIT)) dut (
      .clk_sys(clk_sys),
      .reset(reset),
      .ioctl_downl(ioctl_downl),
      .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr),
      .ioctl_dout(ioctl_dout),
      .port1_req(port1_req),
      .port1_ack(port1_ack),
      .port1_addr(port1_addr),
      .port1_ds(port1_ds),
      .port1_din(port1_din),
      .port1_we(port1_we),
      .rom_loaded(rom_loaded),
      .overflow(overflow)
   );

   // SDRAM controller stand-in: acks each request after a random latency and logs what it saw
   initial begin
      word_t first;
      obs_t  o;
      int    lat;
      int    force_done;
      force_done = 0;
      forever begin
         @(posedge clk_sys); #1;
         port1_ack = 1'b0;
         if (force_done != force_cnt) begin
            force_done++;
            port1_ack = 1'b1;
         end else if (ack_en && port1_req) begin
            first = {port1_addr, port1_ds, port1_din};
            lat = $urandom_range(0, 2);
            repeat (lat) begin @(posedge clk_sys); #1; end
            o.w = {port1_addr, port1_ds,
                   port1_din & {{8{port1_ds[1]}}, {8{port1_ds[0]}}}};
            o.stable = port1_req && ({port1_addr, port1_ds, port1_din} == first);
            o.loaded = rom_loaded;
            obs_q.push_back(o);
            port1_ack = 1'b1;
         end
      end
   end

   // Safety net so a wedged run still ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk_sys); #1; end
   endtask

   // Word list built from the pairing rules: each accepted byte joins, completes or displaces the pending word
   task automatic modelByte(input logic [24:0] a, input logic [7:0] d);
      logic [21:0] wa;
      logic        ln;
      if (a >= LIMIT) return;
      wa = a[22:1];
      ln = a[0];
      if (m_pvalid && m_pend.addr == wa && !m_pend.ds[ln]) begin
         if (ln) m_pend.din[15:8] = d;
         else    m_pend.din[7:0]  = d;
         m_pend.ds[ln] = 1'b1;
         if (m_pend.ds == 2'b11) begin
            exp_q.push_back(m_pend);
            m_pvalid = 1'b0;
         end
      end else begin
         if (m_pvalid) exp_q.push_back(m_pend);
         m_pvalid    = 1'b1;
         m_pend.addr = wa;
         m_pend.ds   = ln ? 2'b10 : 2'b01;
         m_pend.din  = ln ? {d, 8'h00} : {8'h00, d};
      end
   endtask

   task automatic modelFlush();
      if (m_pvalid) exp_q.push_back(m_pend);
      m_pvalid = 1'b0;
   endtask

   task automatic applyStimulus(input logic [24:0] a, input logic [7:0] d, input int gap);
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      modelByte(a, d);
      tick(1);
      ioctl_wr = 1'b0;
      tick(gap);
   endtask

   task automatic startDownload(input string tag);
      ioctl_downl = 1'b1;
      tick(2);
      checkOutput({tag, "_start_rom_loaded"}, 64'(rom_loaded), 64'(0));
      checkOutput({tag, "_start_overflow"}, 64'(overflow), 64'(0));
      checkOutput({tag, "_start_we"}, 64'(port1_we), 64'(1));
   endtask

   task automatic endDownload();
      ioctl_downl = 1'b0;
      modelFlush();
      tick(1);
   endtask

   task automatic lastByteWithFall(input logic [24:0] a, input logic [7:0] d);
      ioctl_addr  = a;
      ioctl_dout  = d;
      ioctl_wr    = 1'b1;
      ioctl_downl = 1'b0;
      modelByte(a, d);
      modelFlush();
      tick(1);
      ioctl_wr = 1'b0;
   endtask

   task automatic finishDownload(input string tag, input logic expOvf);
      int budget;
      budget = 0;
      while (!((obs_q.size() >= obs_rd + exp_q.size()) && rom_loaded === 1'b1) && budget < 1000) begin
         tick(1);
         budget++;
      end
      tick(5);
      checkOutput({tag, "_word_count"}, 64'(obs_q.size() - obs_rd), 64'(exp_q.size()));
      checkOutput({tag, "_rom_loaded"}, 64'(rom_loaded), 64'(1));
      checkOutput({tag, "_overflow"}, 64'(overflow), 64'(expOvf));
      checkOutput({tag, "_req_idle"}, 64'(port1_req), 64'(0));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (obs_rd + i < obs_q.size()) begin
            checkOutput($sformatf("%s_word%0d", tag, i), 64'(obs_q[obs_rd + i].w), 64'(exp_q[i]));
            checkOutput($sformatf("%s_stable%0d", tag, i), 64'(obs_q[obs_rd + i].stable), 64'(1));
            checkOutput($sformatf("%s_early_loaded%0d", tag, i), 64'(obs_q[obs_rd + i].loaded), 64'(0));
         end
      end
      obs_rd = obs_q.size();
      exp_q.delete();
   endtask

   initial begin
      logic [24:0] a;
      logic [24:0] seq;
      int          r;
      int          budget;

      // Reset state
      tick(3);
      reset = 1'b0;
      tick(1);
      checkOutput("reset_req", 64'(port1_req), 64'(0));
      checkOutput("reset_addr", 64'(port1_addr), 64'(0));
      checkOutput("reset_ds", 64'(port1_ds), 64'(0));
      checkOutput("reset_din", 64'(port1_din), 64'(0));
      checkOutput("reset_we", 64'(port1_we), 64'(0));
      checkOutput("reset_rom_loaded", 64'(rom_loaded), 64'(0));
      checkOutput("reset_overflow", 64'(overflow), 64'(0));

      // Two full words
      startDownload("t1");
      applyStimulus(25'd0, 8'h11, 7);
      applyStimulus(25'd1, 8'h22, 7);
      applyStimulus(25'd2, 8'h33, 7);
      applyStimulus(25'd3, 8'h44, 7);
      endDownload();
      finishDownload("t1", 1'b0);

      // Odd length: trailing byte flushed on the falling edge
      startDownload("t2");
      applyStimulus(25'd0, 8'hA1, 7);
      applyStimulus(25'd1, 8'hB2, 7);
      applyStimulus(25'd2, 8'hC3, 7);
      endDownload();
      finishDownload("t2", 1'b0);

      // Out-of-order bytes keep their order as separate words
      startDownload("t3");
      applyStimulus(25'd5, 8'h55, 7);
      applyStimulus(25'd2, 8'h66, 7);
      endDownload();
      finishDownload("t3", 1'b0);

      // Stall the controller and overrun the FIFO
      startDownload("t4");
      ack_en = 1'b0;
      for (int w = 0; w < 12; w++) begin
         applyStimulus(25'(2 * w), 8'($urandom), 1);
         applyStimulus(25'(2 * w + 1), 8'($urandom), 1);
      end
      tick(3);
      checkOutput("t4_stall_req", 64'(port1_req), 64'(1));
      checkOutput("t4_stall_head", 64'({port1_addr, port1_ds, port1_din}), 64'(exp_q[0]));
      checkOutput("t4_overflow_set", 64'(overflow), 64'(1));
      tick(20);
      checkOutput("t4_stall_req_held", 64'(port1_req), 64'(1));
      checkOutput("t4_stall_head_held", 64'({port1_addr, port1_ds, port1_din}), 64'(exp_q[0]));
      while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
      ack_en = 1'b1;
      endDownload();
      finishDownload("t4", 1'b1);

      // Reset while a request is outstanding, then a stray ack
      startDownload("t5");
      ack_en = 1'b0;
      applyStimulus(25'd0, 8'h12, 2);
      applyStimulus(25'd1, 8'h34, 2);
      budget = 0;
      while (port1_req !== 1'b1 && budget < 50) begin tick(1); budget++; end
      checkOutput("t5_req_before_reset", 64'(port1_req), 64'(1));
      reset = 1'b1;
      ioctl_downl = 1'b0;
      tick(1);
      checkOutput("t5_req_dropped", 64'(port1_req), 64'(0));
      reset = 1'b0;
      exp_q.delete();
      m_pvalid = 1'b0;
      force_cnt++;
      tick(4);
      checkOutput("t5_req_after_ack", 64'(port1_req), 64'(0));
      checkOutput("t5_we_empty", 64'(port1_we), 64'(0));
      checkOutput("t5_rom_loaded", 64'(rom_loaded), 64'(0));
      checkOutput("t5_overflow", 64'(overflow), 64'(0));
      ack_en = 1'b1;
      tick(10);
      checkOutput("t5_no_new_req", 64'(obs_q.size() - obs_rd), 64'(0));

      // Address limit: byte at the limit is dropped, byte just below is kept
      startDownload("t6a");
      applyStimulus(LIMIT, 8'h77, 10);
      checkOutput("t6_limit_no_req", 64'(port1_req), 64'(0));
      checkOutput("t6_limit_no_word", 64'(obs_q.size() - obs_rd), 64'(0));
      applyStimulus(LIMIT - 25'd1, 8'h88, 7);
      endDownload();
      finishDownload("t6a", 1'b0);

      // Strobe coinciding with the falling edge lands in the flushed word
      startDownload("t6b");
      applyStimulus(25'h100, 8'h9A, 7);
      applyStimulus(25'h101, 8'hBC, 7);
      lastByteWithFall(25'h102, 8'hDE);
      finishDownload("t6b", 1'b0);

      // Zero-byte download still reports loaded
      startDownload("t7");
      endDownload();
      finishDownload("t7", 1'b0);

      // Randomized downloads: runs, jumps, repeated lanes and out-of-range bytes
      for (int round = 0; round < 4; round++) begin
         startDownload($sformatf("rnd%0d", round));
         seq = 25'($urandom_range(0, 32'hFF00));
         for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)       seq = seq + 25'd1;
            else if (r == 6) seq = 25'($urandom_range(0, 32'hFFFF));
            a = seq;
            if (r == 8) a = LIMIT + 25'($urandom_range(0, 1000));
            if (i == 29 && round[0]) lastByteWithFall(a, 8'($urandom));
            else applyStimulus(a, 8'($urandom), $urandom_range(6, 10));
         end
         if (!round[0]) endDownload();
         finishDownload($sformatf("rnd%0d", round), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
